// File: rtl/mem_wb_if.sv
// Bundle of the ALU-side input, memory req/ack bus and register-file write port
// seen by the memory/write-back stage.
interface mem_wb_if #(
    parameter int REG_AW = 3
);
    logic              in_valid;
    logic              in_ready;
    logic [1:0]        alu_op;
    logic [15:0]       alu_result;
    logic [1:0]        alu_flags;
    logic [15:0]       store_data;
    logic [REG_AW-1:0] dest_reg;
    logic              is_load;
    logic              is_store;
    logic [1:0]        wb_cond;
    logic              mem_req;
    logic              mem_we;
    logic [15:0]       mem_addr;
    logic [15:0]       mem_wdata;
    logic [15:0]       mem_rdata;
    logic              mem_ack;
    logic              rf_we;
    logic [REG_AW-1:0] rf_waddr;
    logic [15:0]       rf_wdata;
    logic [1:0]        flags_q;
    logic              err;

    // Stage side: consumes ALU results and memory responses, drives everything else.
    modport master (
        input  in_valid, alu_op, alu_result, alu_flags, store_data, dest_reg,
               is_load, is_store, wb_cond, mem_rdata, mem_ack,
        output in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr, rf_wdata, flags_q, err
    );

    // Environment side: ALU pipeline, memory and register file.
    modport slave (
        output in_valid, alu_op, alu_result, alu_flags, store_data, dest_reg,
               is_load, is_store, wb_cond, mem_rdata, mem_ack,
        input  in_ready, mem_req, mem_we, mem_addr, mem_wdata,
               rf_we, rf_waddr, rf_wdata, flags_q, err
    );
endinterface

// File: rtl/mem_wb_stage.sv
// Memory/write-back stage behind the 16-bit ALU: conditional execution, flag
// register, load/store over a req/ack bus with timeout, register-file write port.
module mem_wb_stage #(
    parameter int TIMEOUT = 15,
    parameter int REG_AW  = 3
) (
    input  logic     clk,
    input  logic     rst,
    mem_wb_if.master bus
);
    typedef enum logic [0:0] {IDLE, MEM_WAIT} state_t;

    localparam logic [1:0] OP_ADD_A = 2'b00;
    localparam logic [1:0] OP_NAND  = 2'b01;
    localparam logic [1:0] OP_EQ    = 2'b10;
    localparam logic [1:0] OP_ADD_M = 2'b11;
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    state_t            state_reg, state_next;
    logic              in_ready_reg, in_ready_next;
    logic              mem_req_reg, mem_req_next;
    logic              mem_we_reg, mem_we_next;
    logic [15:0]       mem_addr_reg, mem_addr_next;
    logic [15:0]       mem_wdata_reg, mem_wdata_next;
    logic              rf_we_reg, rf_we_next;
    logic [REG_AW-1:0] rf_waddr_reg, rf_waddr_next;
    logic [15:0]       rf_wdata_reg, rf_wdata_next;
    logic [1:0]        flags_reg, flags_next;
    logic              err_reg, err_next;
    logic [7:0]        cnt_reg, cnt_next;
    logic [REG_AW-1:0] pend_dest_reg, pend_dest_next;

    logic accept, is_alu, cond_ok, illegal;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            in_ready_reg  <= 1'b0;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rf_we_reg     <= 1'b0;
            rf_waddr_reg  <= '0;
            rf_wdata_reg  <= '0;
            flags_reg     <= 2'b00;
            err_reg       <= 1'b0;
            cnt_reg       <= '0;
            pend_dest_reg <= '0;
        end else begin
            state_reg     <= state_next;
            in_ready_reg  <= in_ready_next;
            mem_req_reg   <= mem_req_next;
            mem_we_reg    <= mem_we_next;
            mem_addr_reg  <= mem_addr_next;
            mem_wdata_reg <= mem_wdata_next;
            rf_we_reg     <= rf_we_next;
            rf_waddr_reg  <= rf_waddr_next;
            rf_wdata_reg  <= rf_wdata_next;
            flags_reg     <= flags_next;
            err_reg       <= err_next;
            cnt_reg       <= cnt_next;
            pend_dest_reg <= pend_dest_next;
        end
    end

    always_comb begin
        state_next     = state_reg;
        mem_req_next   = mem_req_reg;
        mem_we_next    = mem_we_reg;
        mem_addr_next  = mem_addr_reg;
        mem_wdata_next = mem_wdata_reg;
        rf_we_next     = 1'b0;
        rf_waddr_next  = rf_waddr_reg;
        rf_wdata_next  = rf_wdata_reg;
        flags_next     = flags_reg;
        err_next       = err_reg;
        cnt_next       = cnt_reg;
        pend_dest_next = pend_dest_reg;

        accept  = bus.in_valid && in_ready_reg;
        is_alu  = (bus.alu_op == OP_ADD_A) || (bus.alu_op == OP_NAND);
        cond_ok = (bus.wb_cond == 2'b00) ||
                  (bus.wb_cond == 2'b10 && flags_reg[1]) ||
                  (bus.wb_cond == 2'b01 && flags_reg[0]);
        illegal = (bus.alu_op == OP_ADD_M && (bus.is_load == bus.is_store)) ||
                  (is_alu && bus.wb_cond == 2'b11);

        unique case (state_reg)
            IDLE: begin
                if (accept) begin
                    if (illegal) begin
                        err_next = 1'b1;
                    end else begin
                        unique case (bus.alu_op)
                            OP_ADD_A: if (cond_ok) begin
                                rf_we_next    = 1'b1;
                                rf_waddr_next = bus.dest_reg;
                                rf_wdata_next = bus.alu_result;
                                flags_next    = {bus.alu_flags[1], bus.alu_result == 16'h0000};
                            end
                            OP_NAND: if (cond_ok) begin
                                rf_we_next    = 1'b1;
                                rf_waddr_next = bus.dest_reg;
                                rf_wdata_next = bus.alu_result;
                                flags_next[0] = (bus.alu_result == 16'h0000);
                            end
                            OP_EQ: flags_next[0] = (bus.alu_result == 16'h0000);
                            default: begin
                                state_next     = MEM_WAIT;
                                mem_req_next   = 1'b1;
                                mem_addr_next  = bus.alu_result;
                                mem_we_next    = bus.is_store;
                                mem_wdata_next = bus.is_store ? bus.store_data : 16'h0000;
                                pend_dest_next = bus.dest_reg;
                                cnt_next       = '0;
                            end
                        endcase
                    end
                end
            end
            default: begin
                // An ack on the last counted cycle still completes normally.
                if (bus.mem_ack) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    if (!mem_we_reg) begin
                        rf_we_next    = 1'b1;
                        rf_waddr_next = pend_dest_reg;
                        rf_wdata_next = bus.mem_rdata;
                        flags_next[0] = (bus.mem_rdata == 16'h0000);
                    end
                end else if (cnt_reg == CNT_LAST) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    err_next     = 1'b1;
                end else begin
                    cnt_next = cnt_reg + 8'd1;
                end
            end
        endcase

        in_ready_next = (state_next == IDLE);
    end

    assign bus.in_ready  = in_ready_reg;
    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.rf_we     = rf_we_reg;
    assign bus.rf_waddr  = rf_waddr_reg;
    assign bus.rf_wdata  = rf_wdata_reg;
    assign bus.flags_q   = flags_reg;
    assign bus.err       = err_reg;
endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: directed scenarios plus random instructions checked
// against an instruction-level reference model.
module tb_mem_wb_stage;
    localparam int TIMEOUT = 15;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_wb_if #(.REG_AW(3)) bus ();

    mem_wb_stage #(.TIMEOUT(TIMEOUT), .REG_AW(3)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;
    logic [1:0] m_flags = 2'b00;
    logic       m_err   = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed=%0h expected=%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic scramble();
        bus.alu_op     = 2'($urandom);
        bus.alu_result = 16'($urandom);
        bus.alu_flags  = 2'($urandom);
        bus.store_data = 16'($urandom);
        bus.dest_reg   = 3'($urandom);
        bus.is_load    = 1'($urandom);
        bus.is_store   = 1'($urandom);
        bus.wb_cond    = 2'($urandom);
    endtask

    // ack_at: the mem_req cycle (1-based) in which mem_ack is driven; >TIMEOUT means never.
    task automatic issue(input logic [1:0] op, input logic [15:0] res, input logic [1:0] af,
                         input logic [15:0] sd, input logic [2:0] dest, input logic ld,
                         input logic st, input logic [1:0] cond, input int ack_at,
                         input logic [15:0] rdata);
        int n, k, wr_n, exp_req;
        logic [2:0]  wa;
        logic [15:0] wd, exp_wd;
        bit illegal, is_mem, cond_ok, exp_wr;

        illegal = (op == 2'd3 && ld == st) || (op < 2'd2 && cond == 2'd3);
        is_mem  = (op == 2'd3) && !illegal;
        cond_ok = (cond == 2'd0) || (cond == 2'd2 && m_flags[1]) || (cond == 2'd1 && m_flags[0]);
        exp_wr = 0; exp_req = 0; exp_wd = 16'h0;
        if (illegal) m_err = 1'b1;
        else case (op)
            2'd0: if (cond_ok) begin exp_wr = 1; exp_wd = res; m_flags = {af[1], res == 16'h0}; end
            2'd1: if (cond_ok) begin exp_wr = 1; exp_wd = res; m_flags[0] = (res == 16'h0); end
            2'd2: m_flags[0] = (res == 16'h0);
            default: begin
                if (ack_at >= 1 && ack_at <= TIMEOUT) begin
                    exp_req = ack_at;
                    if (ld) begin exp_wr = 1; exp_wd = rdata; m_flags[0] = (rdata == 16'h0); end
                end else begin
                    exp_req = TIMEOUT;
                    m_err   = 1'b1;
                end
            end
        endcase

        n = 0;
        while (!bus.in_ready && n < 100) begin @(negedge clk); n++; end
        chk("ready_wait", 32'(bus.in_ready), 32'd1);
        bus.alu_op = op; bus.alu_result = res; bus.alu_flags = af; bus.store_data = sd;
        bus.dest_reg = dest; bus.is_load = ld; bus.is_store = st; bus.wb_cond = cond;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        scramble();
        wr_n = 0; wa = '0; wd = '0;
        chk("in_ready_n1", 32'(bus.in_ready), 32'(!is_mem));
        if (bus.rf_we) begin wr_n++; wa = bus.rf_waddr; wd = bus.rf_wdata; end
        k = 0;
        while (bus.mem_req && k < TIMEOUT + 5) begin
            k++;
            chk("mem_addr", 32'(bus.mem_addr), 32'(res));
            chk("mem_we", 32'(bus.mem_we), 32'(st));
            chk("mem_wdata", 32'(bus.mem_wdata), st ? 32'(sd) : 32'd0);
            bus.mem_ack   = (k == ack_at);
            bus.mem_rdata = (k == ack_at) ? rdata : 16'($urandom);
            @(negedge clk);
            bus.mem_ack   = 1'b0;
            bus.mem_rdata = 16'($urandom);
            if (bus.rf_we) begin wr_n++; wa = bus.rf_waddr; wd = bus.rf_wdata; end
        end
        chk("req_cycles", 32'(k), 32'(exp_req));
        @(negedge clk);
        if (bus.rf_we) begin wr_n++; wa = bus.rf_waddr; wd = bus.rf_wdata; end
        chk("wr_count", 32'(wr_n), 32'(exp_wr));
        if (exp_wr && wr_n == 1) begin
            chk("wr_addr", 32'(wa), 32'(dest));
            chk("wr_data", 32'(wd), 32'(exp_wd));
        end
        chk("flags", 32'(bus.flags_q), 32'(m_flags));
        chk("err", 32'(bus.err), 32'(m_err));
        $display("TXN op=%0d res=%h cond=%0d ld=%0d st=%0d ack_at=%0d req=%0d wr=%0d flags=%b err=%0d",
                 op, res, cond, ld, st, ack_at, k, wr_n, bus.flags_q, bus.err);
    endtask

    initial begin
        int r, ack_at;
        logic [1:0]  op, cond;
        logic        ld, st;
        logic [15:0] res, rdata;

        bus.in_valid = 1'b0; bus.mem_ack = 1'b0; bus.mem_rdata = 16'h0;
        scramble();
        repeat (3) @(negedge clk);
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_outputs", {bus.mem_req, bus.mem_we, bus.rf_we, bus.flags_q, bus.err, 26'd0}, 32'd0);
        chk("rst_buses", {bus.mem_addr, bus.mem_wdata}, 32'd0);
        chk("rst_rf", {13'd0, bus.rf_waddr, bus.rf_wdata}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_rst", 32'(bus.in_ready), 32'd1);

        issue(2'd0, 16'h0000, 2'b10, 16'h0, 3'd3, 0, 0, 2'b00, 0, 16'h0);   // add_a -> flags 11
        chk("add_a_flags", 32'(bus.flags_q), 32'd3);
        issue(2'd2, 16'h1234, 2'b00, 16'h0, 3'd0, 0, 0, 2'b00, 0, 16'h0);   // eq clears zero only
        issue(2'd0, 16'h0005, 2'b00, 16'h0, 3'd1, 0, 0, 2'b00, 0, 16'h0);   // flags -> 00
        issue(2'd0, 16'h0005, 2'b00, 16'h0, 3'd2, 0, 0, 2'b10, 0, 16'h0);   // ADC squashed
        chk("squash_flags", 32'(bus.flags_q), 32'd0);
        issue(2'd3, 16'h0040, 2'b00, 16'h0, 3'd4, 1, 0, 2'b00, 3, 16'h0000); // load, ack after 3
        issue(2'd3, 16'h0010, 2'b00, 16'hBEEF, 3'd5, 0, 1, 2'b00, 1, 16'h0); // store, ack first
        issue(2'd3, 16'h0022, 2'b00, 16'h0, 3'd6, 1, 0, 2'b00, TIMEOUT, 16'h00A5); // ack on last cycle
        issue(2'd3, 16'h0040, 2'b00, 16'h0, 3'd7, 1, 0, 2'b00, 999, 16'h0);  // timeout
        issue(2'd0, 16'h0077, 2'b00, 16'h0, 3'd1, 0, 0, 2'b00, 0, 16'h0);    // accepted after abort

        // Reset while a load is waiting; a late ack must not write anything.
        bus.alu_op = 2'd3; bus.alu_result = 16'h0050; bus.dest_reg = 3'd2;
        bus.is_load = 1'b1; bus.is_store = 1'b0; bus.wb_cond = 2'b00; bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        @(negedge clk);
        chk("mid_req_high", 32'(bus.mem_req), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        chk("mid_rst_req", 32'(bus.mem_req), 32'd0);
        chk("mid_rst_flags", 32'(bus.flags_q), 32'd0);
        chk("mid_rst_err", 32'(bus.err), 32'd0);
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
        rst = 1'b0; bus.mem_ack = 1'b1; bus.mem_rdata = 16'h1111;
        @(negedge clk);
        bus.mem_ack = 1'b0;
        chk("late_ack_we", 32'(bus.rf_we), 32'd0);
        @(negedge clk);
        chk("late_ack_we2", 32'(bus.rf_we), 32'd0);
        chk("late_ack_req", 32'(bus.mem_req), 32'd0);
        m_flags = 2'b00; m_err = 1'b0;

        issue(2'd3, 16'h0030, 2'b00, 16'h0, 3'd1, 1, 1, 2'b00, 1, 16'h0);    // both set: illegal
        chk("illegal_err", 32'(bus.err), 32'd1);

        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        m_flags = 2'b00; m_err = 1'b0;

        for (int i = 0; i < 60; i++) begin
            op = 2'($urandom_range(0, 3));
            r = $urandom_range(0, 15);
            cond = (r == 0) ? 2'b11 : 2'(r % 3);
            r = $urandom_range(0, 19);
            if (r == 0) begin ld = 1; st = 1; end
            else if (r == 1) begin ld = 0; st = 0; end
            else begin ld = 1'($urandom); st = !ld; end
            res   = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            rdata = ($urandom_range(0, 3) == 0) ? 16'h0 : 16'($urandom);
            ack_at = $urandom_range(1, TIMEOUT + 3);
            issue(op, res, 2'($urandom), 16'($urandom), 3'($urandom), ld, st, cond, ack_at, rdata);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_wb_stage.md
Name: mem_wb_stage

Overview:
- Memory/write-back stage directly downstream of the 16-bit ALU.
- Consumes the ALU result, flags and instruction control.
- Performs load/store accesses using the add_m result as the address, over a req/ack memory handshake.
- Evaluates carry/zero-conditional execution, maintains the architectural carry/zero flag register, and drives the register-file write port.

Parameters:
- TIMEOUT, 15: max cycles mem_req may stay high without mem_ack before abort (1..255).
- REG_AW, 3: register-file address width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  ALU result/control valid this cycle.
- in_ready  output  1  stage can accept; transfer when in_valid && in_ready.
- alu_op  input  2  00 add_a, 01 nand, 10 eq, 11 add_m.
- alu_result  input  16  ALU result (address for add_m).
- alu_flags  input  2  [1] carry, [0] zero from ALU.
- store_data  input  16  data for store.
- dest_reg  input  REG_AW  write-back register.
- is_load  input  1  add_m is a load.
- is_store  input  1  add_m is a store.
- wb_cond  input  2  00 always, 10 only if flags_q[1], 01 only if flags_q[0], 11 illegal.
- mem_req  output  1  memory request.
- mem_we  output  1  1 = write.
- mem_addr  output  16  access address.
- mem_wdata  output  16  store data.
- mem_rdata  input  16  load data, valid with mem_ack.
- mem_ack  input  1  access complete.
- rf_we  output  1  one-cycle register write strobe.
- rf_waddr  output  REG_AW  write address.
- rf_wdata  output  16  write data.
- flags_q  output  2  architectural flags, [1] carry, [0] zero.
- err  output  1  sticky error: timeout, illegal control.

Behaviour:
- Reset (rst high at rising edge):
  - State returns to IDLE.
  - Outputs cleared: in_ready=0 while rst high, mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0, rf_we=0, rf_waddr=0, rf_wdata=0, flags_q=00, err=0.
  - in_ready=1 the first cycle after rst falls.
- Reset mid-transaction: mem_req drops at that edge and no write-back or flag update occurs.
- States:
  - IDLE: in_ready=1.
  - MEM_WAIT: in_ready=0, mem_req=1.
  - All outputs are registered.
- Condition check at acceptance:
  - Applies to alu_op 00/01 only.
  - Uses flags_q as held in the acceptance cycle.
  - Failed condition squashes the instruction: no rf_we, no flag change, stays IDLE.
- add_a, accepted cycle N, condition met:
  - Cycle N+1: rf_we=1, rf_waddr=dest_reg, rf_wdata=alu_result.
  - flags_q <= {alu_flags[1], alu_result==0}.
- nand, accepted cycle N, condition met: same write-back timing; only flags_q[0] <= (alu_result==0).
- eq: no register write; flags_q[0] <= (alu_result==0); carry unchanged.
- Zero flag: always recomputed here from the 16-bit value, never taken from alu_flags[0].
- Flag updates take effect at the end of the acceptance cycle, so a back-to-back conditional instruction sees them (no hazard).
- add_m with exactly one of is_load/is_store, accepted cycle N:
  - Go to MEM_WAIT.
  - From cycle N+1: mem_req=1, mem_addr=alu_result, mem_we=is_store, mem_wdata=store_data (0 for loads).
  - These outputs are held stable until ack or abort.
- mem_ack handling:
  - Sampled only while mem_req=1; ignored otherwise.
  - Earliest ack is cycle N+1.
  - Ack in cycle M: mem_req=0 and state=IDLE in cycle M+1.
  - Load: additionally in cycle M+1, rf_we=1, rf_wdata=mem_rdata captured at M, and flags_q[0] <= (mem_rdata==0).
  - Store: no rf_we, no flag change.
- Timeout:
  - Counter increments each mem_req-high cycle without ack.
  - When TIMEOUT cycles have elapsed with no ack: mem_req drops next edge, err<=1, no write-back, return to IDLE.
  - Ack on the final counted cycle takes priority over timeout.
- Illegal control: add_m with both or neither of is_load/is_store, or wb_cond=11 on op 00/01:
  - err<=1, instruction dropped, no memory or write side effects, stays IDLE.
- err is cleared only by rst.
- rf_we is never high for more than one cycle per instruction.

Test Plan:
- add_a: alu_result=0x0000, alu_flags=10, dest=3, wb_cond=00 -> next cycle rf_we=1, rf_waddr=3, rf_wdata=0; flags_q=11.
- ADC squash: flags_q=00, add_a with wb_cond=10, result 0x0005 -> no rf_we, flags_q stays 00, in_ready stays 1.
- Load: add_m is_load, alu_result=0x0040; ack after 3 cycles with mem_rdata=0x0000:
  - mem_req high 3 cycles with addr 0x0040 and mem_we=0.
  - Cycle after ack: rf_we=1, rf_wdata=0; flags_q[0]=1.
- Store: add_m is_store, addr 0x0010, store_data 0xBEEF, ack on first cycle -> mem_req high exactly 1 cycle, mem_we=1, wdata=0xBEEF; no rf_we.
- Timeout: TIMEOUT=15, load with ack never asserted -> mem_req high 15 cycles then low; err=1; no rf_we; next instruction accepted.
- Reset and illegal control:
  - rst during MEM_WAIT -> mem_req=0 and flags_q=00 next cycle; a late ack causes no write.
  - is_load=is_store=1 -> err=1, no mem_req.
